// File: rtl/nios_system_mem_copy_master.sv
// nios_system_mem_copy_master
//
// Avalon-MM master that copies a block of words inside a single-port
// on-chip memory (read latency 1). Each word is moved with a strictly
// sequential read -> capture -> write sequence, and a running additive
// checksum of the copied data is reported together with a done pulse.
//
// Ports:
//   clk, reset           system clock, asynchronous active-high reset
//   start                one-cycle request, sampled only while idle
//   src_addr, dst_addr   first source / destination word address
//   length               number of words to copy (0 .. 2**ADDR_W)
//   busy                 high from the cycle after start through done
//   done                 one-cycle completion pulse
//   checksum             sum of copied words, stable from done to next start
//   avm_*                Avalon-MM master port towards the memory slave
module nios_system_mem_copy_master #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     src_addr,
  input  logic [ADDR_W-1:0]     dst_addr,
  input  logic [LEN_W-1:0]      length,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_W-1:0]     checksum,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_chipselect,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  output logic [DATA_W-1:0]     avm_writedata,
  input  logic                  avm_waitrequest,
  input  logic [DATA_W-1:0]     avm_readdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_FIN
  } state_t;

  state_t              state_q,    state_d;
  logic                busy_q,     busy_d;
  logic                done_q,     done_d;
  logic                rd_q,       rd_d;
  logic                wr_q,       wr_d;
  logic [ADDR_W-1:0]   addr_q,     addr_d;
  logic [DATA_W-1:0]   wdata_q,    wdata_d;
  logic [DATA_W-1:0]   csum_q,     csum_d;
  logic [ADDR_W-1:0]   src_q,      src_d;
  logic [ADDR_W-1:0]   dst_q,      dst_d;
  logic [LEN_W-1:0]    rem_q,      rem_d;

  // All bus outputs are computed for the *next* state so that they come
  // straight out of flops; a stalled request simply keeps its values.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    csum_d  = csum_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d  = src_addr;
          dst_d  = dst_addr;
          rem_d  = length;
          csum_d = '0;
          busy_d = 1'b1;
          if (length == '0) begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end else begin
            state_d = S_RD;
            rd_d    = 1'b1;
            addr_d  = src_addr;
          end
        end
      end

      S_RD: begin
        if (!avm_waitrequest) begin
          rd_d    = 1'b0;
          state_d = S_CAP;
        end
      end

      // Read data is valid exactly one cycle after the accepted read.
      S_CAP: begin
        wdata_d = avm_readdata;
        csum_d  = csum_q + avm_readdata;
        wr_d    = 1'b1;
        addr_d  = dst_q;
        state_d = S_WR;
      end

      S_WR: begin
        if (!avm_waitrequest) begin
          wr_d  = 1'b0;
          src_d = src_q + ADDR_W'(1);
          dst_d = dst_q + ADDR_W'(1);
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end else begin
            state_d = S_RD;
            rd_d    = 1'b1;
            addr_d  = src_q + ADDR_W'(1);
          end
        end
      end

      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      csum_q  <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      csum_q  <= csum_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign checksum       = csum_q;
  assign avm_address    = addr_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign avm_chipselect = rd_q | wr_q;
  assign avm_byteenable = '1;
  assign avm_writedata  = wdata_q;

endmodule

// File: tb/tb_nios_system_mem_copy_master.sv
// Self-checking bench for nios_system_mem_copy_master: a behavioural
// memory slave with optional random waitrequest, and a reference model
// that performs the copy as a plain ascending array loop.
module tb_nios_system_mem_copy_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] src_addr, dst_addr;
  logic [12:0] length;
  logic        busy, done;
  logic [31:0] checksum;
  logic [11:0] avm_address;
  logic        avm_chipselect, avm_read, avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic        waitreq;
  logic [31:0] avm_readdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nios_system_mem_copy_master dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .src_addr        (src_addr),
    .dst_addr        (dst_addr),
    .length          (length),
    .busy            (busy),
    .done            (done),
    .checksum        (checksum),
    .avm_address     (avm_address),
    .avm_chipselect  (avm_chipselect),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_byteenable  (avm_byteenable),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (waitreq),
    .avm_readdata    (avm_readdata)
  );

  // ---------------- memory slave (read latency 1) ----------------
  logic [31:0] mem     [4096];
  logic [31:0] mem_exp [4096];
  logic        bd_we;
  logic [11:0] bd_addr;
  logic [31:0] bd_data;
  logic [11:0] rd_log[$];
  logic [11:0] wr_log[$];

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    if (avm_read && !waitreq) begin
      avm_readdata <= mem[avm_address];
      rd_log.push_back(avm_address);
    end
    if (avm_write && !waitreq) begin
      mem[avm_address] <= avm_writedata;
      wr_log.push_back(avm_address);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: copy word by word in ascending order, wrapping addresses.
  function automatic logic [31:0] model_copy(input logic [11:0] s, input logic [11:0] d, input int n);
    logic [31:0] sum;
    logic [31:0] w;
    sum = '0;
    for (int i = 0; i < n; i++) begin
      w = mem_exp[s];
      mem_exp[d] = w;
      sum = sum + w;
      s = s + 12'd1;
      d = d + 12'd1;
    end
    return sum;
  endfunction

  function automatic int mem_errs();
    int e;
    e = 0;
    for (int i = 0; i < 4096; i++)
      if (mem[i] !== mem_exp[i]) e++;
    return e;
  endfunction

  task automatic poke_mem(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d; mem_exp[a] = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic run_copy(input logic [11:0] s, input logic [11:0] d, input int n,
                          input bit stall_en, input bit poke, input string tag);
    logic [31:0] exp_sum;
    logic [45:0] snap, cur;
    int rd0, wr0, k, stalls, e_busy, e_bus, e_stall, e_addr;
    bit got_done, prev_stall;
    rd0 = rd_log.size(); wr0 = wr_log.size();
    exp_sum = model_copy(s, d, n);
    k = 0; stalls = 0; e_busy = 0; e_bus = 0; e_stall = 0; e_addr = 0;
    got_done = 1'b0; prev_stall = 1'b0; snap = '0;
    @(negedge clk);
    src_addr = s; dst_addr = d; length = 13'(n); start = 1'b1; waitreq = 1'b0;
    while (k < 20000 && !got_done) begin
      @(negedge clk);
      k++;
      start = 1'b0;
      if (poke && k == 2) begin
        start = 1'b1; src_addr = 12'($urandom); dst_addr = 12'($urandom); length = 13'd7;
      end
      cur = {avm_read, avm_write, avm_address, avm_writedata};
      if (prev_stall && cur !== snap) e_stall++;
      if (busy !== 1'b1) e_busy++;
      if ((avm_read && avm_write) || (avm_chipselect !== (avm_read | avm_write))) e_bus++;
      if (done === 1'b1) begin
        got_done = 1'b1;
      end else begin
        waitreq    = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
        prev_stall = (avm_read | avm_write) && waitreq;
        if (prev_stall) stalls++;
        snap = cur;
      end
    end
    waitreq = 1'b0;
    chk({tag, "_done_seen"}, 64'(got_done), 64'd1);
    chk({tag, "_latency"}, 64'(k), 64'(3 * n + 1 + stalls));
    chk({tag, "_checksum"}, 64'(checksum), 64'(exp_sum));
    chk({tag, "_busy_during"}, 64'(e_busy), 64'd0);
    chk({tag, "_bus_rules"}, 64'(e_bus), 64'd0);
    chk({tag, "_stall_stable"}, 64'(e_stall), 64'd0);
    // A start presented in the done cycle must not launch a new copy.
    if (poke) begin
      start = 1'b1; src_addr = 12'($urandom); length = 13'd5;
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    chk({tag, "_done_after"}, 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    chk({tag, "_checksum_hold"}, 64'(checksum), 64'(exp_sum));
    chk({tag, "_reads"}, 64'(rd_log.size() - rd0), 64'(n));
    chk({tag, "_writes"}, 64'(wr_log.size() - wr0), 64'(n));
    for (int i = 0; i < n && rd0 + i < rd_log.size() && wr0 + i < wr_log.size(); i++) begin
      if (rd_log[rd0 + i] !== s + 12'(i)) e_addr++;
      if (wr_log[wr0 + i] !== d + 12'(i)) e_addr++;
    end
    chk({tag, "_addr_seq"}, 64'(e_addr), 64'd0);
    chk({tag, "_mem"}, 64'(mem_errs()), 64'd0);
    $display("copy %s src=%03h dst=%03h len=%0d stalls=%0d cycles=%0d checksum=%08h",
             tag, s, d, n, stalls, k, checksum);
  endtask

  task automatic abort_copy(input logic [11:0] s, input logic [11:0] d, input int n);
    int wr0, k, e_done;
    logic [31:0] unused_sum;
    wr0 = wr_log.size(); k = 0; e_done = 0;
    unused_sum = model_copy(s, d, 2);  // only two words land before reset
    @(negedge clk);
    src_addr = s; dst_addr = d; length = 13'(n); start = 1'b1; waitreq = 1'b0;
    while (k < 1000 && (wr_log.size() - wr0) < 2) begin
      @(negedge clk);
      k++;
      start = 1'b0;
      if (done) e_done++;
    end
    chk("abort_two_writes", 64'(wr_log.size() - wr0), 64'd2);
    reset = 1'b1;
    #1;
    chk("abort_ctrl_zero", 64'({busy, done, avm_read, avm_write, avm_chipselect}), 64'd0);
    chk("abort_addr_zero", 64'(avm_address), 64'd0);
    chk("abort_wdata_zero", 64'(avm_writedata), 64'd0);
    chk("abort_csum_zero", 64'(checksum), 64'd0);
    repeat (3) begin
      @(negedge clk);
      if (done) e_done++;
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) e_done++;
    end
    chk("abort_no_done", 64'(e_done), 64'd0);
    chk("abort_writes_kept", 64'(wr_log.size() - wr0), 64'd2);
    chk("abort_mem", 64'(mem_errs()), 64'd0);
    $display("abort src=%03h dst=%03h len=%0d after 2 writes (unused sum %08h)", s, d, n, unused_sum);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
    waitreq = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 64'({busy, done, avm_read, avm_write, avm_chipselect}), 64'd0);
    chk("rst_addr", 64'(avm_address), 64'd0);
    chk("rst_wdata", 64'(avm_writedata), 64'd0);
    chk("rst_csum", 64'(checksum), 64'd0);
    chk("byteenable", 64'(avm_byteenable), 64'hF);
    reset = 1'b0;

    // Random fill of the whole memory, one word per cycle.
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      bd_we = 1'b1; bd_addr = 12'(i); bd_data = $urandom; mem_exp[i] = bd_data;
    end
    @(negedge clk);
    bd_we = 1'b0;

    for (int i = 0; i < 4; i++) poke_mem(12'h010 + 12'(i), 32'(i + 1));
    run_copy(12'h010, 12'h100, 4, 1'b0, 1'b0, "basic");
    chk("basic_csum_const", 64'(checksum), 64'h0000000A);

    run_copy(12'h200, 12'h300, 0, 1'b0, 1'b0, "len0");
    run_copy(12'hFFE, 12'h7FE, 4, 1'b0, 1'b0, "wrap");
    run_copy(12'h400, 12'h500, 16, 1'b1, 1'b0, "stall16");

    abort_copy(12'h040, 12'h840, 8);
    run_copy(12'h040, 12'h880, 8, 1'b1, 1'b0, "after_abort");

    poke_mem(12'h600, 32'hFFFF_FFFF);
    poke_mem(12'h601, 32'h0000_0002);
    run_copy(12'h600, 12'h700, 2, 1'b0, 1'b1, "ignore_start");
    chk("wrap_csum_const", 64'(checksum), 64'h00000001);

    run_copy(12'h020, 12'h022, 6, 1'b0, 1'b0, "overlap");
    for (int t = 0; t < 4; t++)
      run_copy(12'($urandom), 12'($urandom), int'($urandom_range(1, 40)), 1'b1, 1'b0, "random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
